// File: rtl/branch_resolve_if.sv
// EX-to-resolve instruction bus plus the redirect handshake back to fetch.
// The DUT uses the slave modport; the EX/fetch side uses master.
interface branch_resolve_if #(parameter int WIDTH = 32);
  logic             ex_valid;
  logic             ex_ready;
  logic             ex_branch;
  logic             ex_jal;
  logic             ex_jalr;
  logic [2:0]       funct3;
  logic             BrUn;
  logic             BrEq;
  logic             BrLT;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] imm;
  logic [WIDTH-1:0] rs1;
  logic             pred_taken;
  logic             redirect_valid;
  logic [WIDTH-1:0] redirect_pc;
  logic             redirect_ready;
  logic             flush;
  logic             illegal_br;

  modport master (
    output ex_valid, ex_branch, ex_jal, ex_jalr, funct3, BrEq, BrLT,
           pc, imm, rs1, pred_taken, redirect_ready,
    input  ex_ready, BrUn, redirect_valid, redirect_pc, flush, illegal_br
  );

  modport slave (
    input  ex_valid, ex_branch, ex_jal, ex_jalr, funct3, BrEq, BrLT,
           pc, imm, rs1, pred_taken, redirect_ready,
    output ex_ready, BrUn, redirect_valid, redirect_pc, flush, illegal_br
  );
endinterface

// File: rtl/branch_resolve.sv
// Resolves EX-stage branches/jumps; on mispredict raises a registered redirect 1 cycle after accept,
// holds it until redirect_ready, then flushes. Optional counters via BRANCH_RESOLVE_STATS_EN.
module branch_resolve #(
  parameter int WIDTH        = 32,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  branch_resolve_if.slave    bus
`ifdef BRANCH_RESOLVE_STATS_EN
  ,
  output logic [31:0]        br_count,
  output logic [31:0]        mispred_count
`endif
);

  typedef enum logic [1:0] {IDLE, REDIRECT, FLUSH} state_t;

  state_t           state, state_nxt;
  logic [2:0]       cnt;
  logic [WIDTH-1:0] redirect_pc_q;
  logic [WIDTH-1:0] jalr_sum;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] pc_nxt;
  logic             taken;
  logic             accept;
  logic             mispredict;
  logic             illegal;
  logic             illegal_q;

  // Branch condition decode; funct3 010/011 are reserved and never taken.
  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    if (bus.ex_jal || bus.ex_jalr) begin
      taken = 1'b1;
    end else if (bus.ex_branch) begin
      case (bus.funct3)
        3'b000:         taken = bus.BrEq;
        3'b001:         taken = !bus.BrEq;
        3'b100, 3'b110: taken = bus.BrLT;
        3'b101, 3'b111: taken = !bus.BrLT;
        default:        illegal = 1'b1;
      endcase
    end
  end

  always_comb begin
    jalr_sum = bus.rs1 + bus.imm;
    target   = bus.ex_jalr ? {jalr_sum[WIDTH-1:1], 1'b0} : bus.pc + bus.imm;
    pc_nxt   = taken ? target : bus.pc + WIDTH'(4);
  end

  assign mispredict = taken != bus.pred_taken;
  assign accept     = bus.ex_valid && bus.ex_ready;
  assign bus.BrUn   = bus.funct3[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (accept && mispredict) state_nxt = REDIRECT;
      REDIRECT: if (bus.redirect_ready)   state_nxt = FLUSH;
      FLUSH:    if (cnt == 3'd0)          state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.ex_ready       = (state == IDLE);
    bus.redirect_valid = (state == REDIRECT);
    bus.flush          = (state == REDIRECT) || (state == FLUSH);
    bus.redirect_pc    = redirect_pc_q;
    bus.illegal_br     = illegal_q;
  end

  // The counter covers only the FLUSH portion; REDIRECT cycles flush on top of it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt           <= 3'd0;
      redirect_pc_q <= '0;
      illegal_q     <= 1'b0;
    end else begin
      if (state == REDIRECT && bus.redirect_ready)
        cnt <= 3'(FLUSH_CYCLES - 1);
      else if (state == FLUSH && cnt != 3'd0)
        cnt <= cnt - 3'd1;
      if (accept && mispredict)
        redirect_pc_q <= pc_nxt;
      illegal_q <= accept && illegal;
    end
  end

`ifdef BRANCH_RESOLVE_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_count      <= 32'd0;
      mispred_count <= 32'd0;
    end else if (accept) begin
      br_count <= br_count + 32'd1;
      if (mispredict) mispred_count <= mispred_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Scoreboard bench for branch_resolve: expected redirect PCs are queued at issue and popped at the redirect.
module tb_branch_resolve;
  localparam int W  = 32;
  localparam int FC = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  branch_resolve_if #(.WIDTH(W)) bus();

`ifdef BRANCH_RESOLVE_STATS_EN
  logic [31:0] br_count;
  logic [31:0] mispred_count;
`endif

  branch_resolve #(.WIDTH(W), .FLUSH_CYCLES(FC)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus.slave)
`ifdef BRANCH_RESOLVE_STATS_EN
    ,
    .br_count      (br_count),
    .mispred_count (mispred_count)
`endif
  );

  int passed = 0;
  int total  = 0;
  int nacc   = 0;
  int nmis   = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    if (obs === exp) passed++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
  endtask

  // cls: 0 branch, 1 jal, 2 jalr. Drives one instruction and checks the accept-edge outputs.
  task automatic issue(input int cls, input logic [2:0] f3, input logic eq, input logic lt,
                       input logic [W-1:0] pc, input logic [W-1:0] imm, input logic [W-1:0] rs1,
                       input logic pred);
    logic         tk;
    logic         ill;
    logic [W-1:0] tgt;
    logic [W-1:0] exp_pc;
    tk  = 1'b0;
    ill = 1'b0;
    if (cls != 0) tk = 1'b1;
    else begin
      case (f3)
        3'b000:         tk = eq;
        3'b001:         tk = !eq;
        3'b100, 3'b110: tk = lt;
        3'b101, 3'b111: tk = !lt;
        default:        ill = 1'b1;
      endcase
    end
    tgt    = (cls == 2) ? ((rs1 + imm) & ~32'h1) : (pc + imm);
    exp_pc = tk ? tgt : (pc + 32'd4);

    bus.ex_branch  = (cls == 0);
    bus.ex_jal     = (cls == 1);
    bus.ex_jalr    = (cls == 2);
    bus.funct3     = f3;
    bus.BrEq       = eq;
    bus.BrLT       = lt;
    bus.pc         = pc;
    bus.imm        = imm;
    bus.rs1        = rs1;
    bus.pred_taken = pred;
    bus.ex_valid   = 1'b1;
    #1;
    check("ex_ready_idle", bus.ex_ready, 1);
    check("BrUn", bus.BrUn, f3[1]);
    @(posedge clk); #1;
    bus.ex_valid = 1'b0;
    nacc++;
    check("illegal_br", bus.illegal_br, ill);
    if (tk != pred) begin
      nmis++;
      exp_q.push_back(exp_pc);
      check("redirect_valid_lat", bus.redirect_valid, 1);
    end else begin
      check("no_redirect", bus.redirect_valid, 0);
      check("ex_ready_kept", bus.ex_ready, 1);
    end
  endtask

  // Holds redirect_ready low for 'hold' cycles (with junk EX traffic), then completes the flush.
  task automatic drain(input int hold);
    logic [W-1:0] exp;
    int           n;
    check("sb_size", exp_q.size(), 1);
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
    check("redirect_pc", bus.redirect_pc, exp);
    for (int i = 0; i < hold; i++) begin
      bus.ex_valid       = 1'b1;
      bus.ex_branch      = 1'b1;
      bus.ex_jal         = 1'b0;
      bus.ex_jalr        = 1'b0;
      bus.funct3         = 3'b000;
      bus.BrEq           = 1'b1;
      bus.pred_taken     = 1'b0;
      bus.pc             = $urandom;
      bus.redirect_ready = 1'b0;
      @(posedge clk); #1;
      check("hold_valid", bus.redirect_valid, 1);
      check("hold_pc", bus.redirect_pc, exp);
      check("hold_ex_ready", bus.ex_ready, 0);
      check("hold_flush", bus.flush, 1);
      check("hold_illegal", bus.illegal_br, 0);
    end
    bus.ex_valid       = 1'b0;
    bus.redirect_ready = 1'b1;
    #1;
    check("flush_in_redirect", bus.flush, 1);
    @(posedge clk); #1;
    bus.redirect_ready = 1'b0;
    check("valid_dropped", bus.redirect_valid, 0);
    n = 0;
    while (bus.flush && n < 20) begin
      n++;
      @(posedge clk); #1;
    end
    check("flush_len", n, FC);
    check("ex_ready_after", bus.ex_ready, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, want $finish");
    $fatal(1);
  end

  initial begin
    bus.ex_valid = 0; bus.ex_branch = 0; bus.ex_jal = 0; bus.ex_jalr = 0;
    bus.funct3 = 0; bus.BrEq = 0; bus.BrLT = 0; bus.pc = 0; bus.imm = 0;
    bus.rs1 = 0; bus.pred_taken = 0; bus.redirect_ready = 0;
    #12;
    check("rst_valid", bus.redirect_valid, 0);
    check("rst_pc", bus.redirect_pc, 0);
    check("rst_flush", bus.flush, 0);
    check("rst_illegal", bus.illegal_br, 0);
    check("rst_ex_ready", bus.ex_ready, 1);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // BEQ taken, predicted not-taken
    issue(0, 3'b000, 1'b1, 1'b0, 32'h100, 32'h20, 32'h0, 1'b0);
    drain(0);
    // BGEU with BrLT=1: not taken; mispredicted then correctly predicted
    issue(0, 3'b111, 1'b0, 1'b1, 32'h200, 32'h40, 32'h0, 1'b1);
    drain(1);
    issue(0, 3'b111, 1'b0, 1'b1, 32'h200, 32'h40, 32'h0, 1'b0);
    // JALR clears bit 0; JAL wraps around
    issue(2, 3'b000, 1'b0, 1'b0, 32'h500, 32'h2, 32'h1001, 1'b0);
    drain(0);
    issue(1, 3'b000, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h8, 32'h0, 1'b0);
    drain(0);
    // BLT with negative offset, fetch stalls 5 cycles
    issue(0, 3'b100, 1'b0, 1'b1, 32'h40, 32'hFFFF_FFF0, 32'h0, 1'b0);
    drain(5);

    // Reset while in FLUSH
    issue(0, 3'b001, 1'b0, 1'b0, 32'h700, 32'h10, 32'h0, 1'b0);
    check("sb_size_rst", exp_q.size(), 1);
    check("redirect_pc_rst", bus.redirect_pc, exp_q.pop_front());
    bus.redirect_ready = 1'b1;
    @(posedge clk); #1;
    bus.redirect_ready = 1'b0;
    check("in_flush", bus.flush, 1);
    @(negedge clk) rst_n = 1'b0;
    #1;
    check("arst_valid", bus.redirect_valid, 0);
    check("arst_pc", bus.redirect_pc, 0);
    check("arst_flush", bus.flush, 0);
    check("arst_illegal", bus.illegal_br, 0);
    check("arst_ex_ready", bus.ex_ready, 1);
    exp_q.delete();
    nacc = 0;
    nmis = 0;
    @(posedge clk); #1;
    check("arst_flush_held", bus.flush, 0);
    @(negedge clk) rst_n = 1'b1;
    issue(0, 3'b001, 1'b0, 1'b0, 32'h800, 32'h24, 32'h0, 1'b0);
    drain(0);

    // Reserved funct3 predicted taken: falls through to pc+4
    issue(0, 3'b010, 1'b1, 1'b1, 32'h300, 32'h40, 32'h0, 1'b1);
    drain(1);
    issue(0, 3'b111, 1'b0, 1'b1, 32'h200, 32'h40, 32'h0, 1'b0);

`ifdef BRANCH_RESOLVE_STATS_EN
    check("br_count", br_count, 32'(nacc));
    check("mispred_count", mispred_count, 32'(nmis));
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/branch_resolve.md
BRANCH_RESOLVE -- requirements
Module: branch_resolve

Interface
REQ-001 Parameter WIDTH, default 32: datapath/address width.
REQ-002 Parameter FLUSH_CYCLES, default 2: cycles the flush output stays high after a redirect is accepted; legal range 1..7.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 ex_valid  input  1  EX stage holds a valid control-flow instruction.
REQ-006 ex_ready  output  1  block accepts the EX instruction this cycle.
REQ-007 ex_branch, ex_jal, ex_jalr  input  1 each  instruction class; at most one is high.
REQ-008 funct3  input  3  branch condition code.
REQ-009 BrUn  output  1  compare mode to the branch comparator: 0 signed, 1 unsigned.
REQ-010 BrEq, BrLT  input  1 each  comparator results for the current rs1/rs2.
REQ-011 pc, imm, rs1  input  WIDTH each  instruction PC, sign-extended immediate, rs1 value.
REQ-012 pred_taken  input  1  fetch-stage prediction for this instruction.
REQ-013 redirect_valid  output  1, redirect_pc  output  WIDTH, redirect_ready  input  1  valid/ready handshake to fetch.
REQ-014 flush  output  1  kill IF/ID contents.
REQ-015 illegal_br  output  1  one-cycle pulse on an accepted branch with funct3 010 or 011.

Function
REQ-016 BrUn SHALL equal funct3[1], combinationally.
REQ-017 Taken SHALL be: 000 BrEq; 001 !BrEq; 100/110 BrLT; 101/111 !BrLT; 010/011 not taken; jal/jalr always taken.
REQ-018 Target SHALL be pc+imm for branch/jal and (rs1+imm) with bit 0 cleared for jalr; all sums truncated modulo 2^WIDTH (wrap-around, no overflow flag).
REQ-019 An instruction SHALL be accepted when ex_valid && ex_ready; ex_ready SHALL be high only in IDLE.
REQ-020 Mispredict SHALL be (taken != pred_taken); the redirect PC SHALL be the target if taken, else pc+4 (modulo 2^WIDTH).
REQ-021 FSM states IDLE, REDIRECT, FLUSH. IDLE->REDIRECT on an accepted mispredict; otherwise IDLE is held.
REQ-022 In REDIRECT, redirect_valid=1 and redirect_pc SHALL be registered and stable until the handshake; on redirect_ready the FSM SHALL move to FLUSH.
REQ-023 flush SHALL be high during every REDIRECT cycle and for exactly FLUSH_CYCLES cycles in FLUSH; a down-counter loads FLUSH_CYCLES-1 on entry, and FLUSH->IDLE when it reaches 0.
REQ-024 Redirect latency: redirect_valid SHALL assert on the first edge after acceptance (1 cycle).
REQ-025 ex_valid while not IDLE SHALL be ignored, with no state change.
REQ-026 Illegal funct3 with pred_taken=1 SHALL redirect to pc+4; illegal_br SHALL pulse in the cycle after acceptance.

Reset
REQ-027 rst_n low SHALL immediately force IDLE, with redirect_valid=0, redirect_pc=0, flush=0, illegal_br=0, counter=0 and stats=0, including mid-REDIRECT or mid-FLUSH; a pending redirect SHALL be dropped.
REQ-028 The first acceptance SHALL be possible in the first cycle after rst_n deasserts.

Configuration
REQ-029 Macro BRANCH_RESOLVE_STATS_EN: when defined, adds outputs br_count and mispred_count (32 bits each, wrapping). They count accepted instructions and accepted mispredicts, and clear on reset. When undefined, these ports and their logic SHALL be absent, with no other behavioural change.

Verification
REQ-030 BEQ with BrEq=1, pc=0x100, imm=0x20, pred_taken=0 -> redirect_valid next cycle, redirect_pc=0x120, flush for 1+FLUSH_CYCLES cycles after redirect_ready.
REQ-031 BGEU with BrLT=1, pred_taken=1, pc=0x200 -> BrUn=1, redirect_pc=0x204; pred_taken=0 -> no redirect, ex_ready stays 1.
REQ-032 JALR with rs1=0x1001, imm=0x2 -> redirect_pc=0x1002; pc=0xFFFFFFFC, imm=8 JAL -> redirect_pc=0x4 (wrap-around).
REQ-033 redirect_ready held 0 for 5 cycles -> redirect_valid/redirect_pc stable, ex_ready=0, flush=1; new ex_valid ignored.
REQ-034 rst_n pulsed low in FLUSH -> all outputs 0 asynchronously; a next-cycle BNE mispredict is accepted normally.
REQ-035 funct3=010 with pred_taken=1 -> illegal_br pulse, redirect_pc=pc+4; with BRANCH_RESOLVE_STATS_EN, after 3 accepts/2 mispredicts -> br_count=3, mispred_count=2.
